// File: rtl/instr_fetch.sv
// Instruction fetch stage: byte PC, word-addressed imem request,
// and the IF/ID pipeline register with valid/ready hold behaviour.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        id_ready,
   output logic        ifid_valid,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_instr,
   output logic        misalign,
   output logic [31:0] fetch_count
);

   logic [31:0] pc;
   logic        load;
   logic        rd_mis;

   // IF/ID may take a new word when not frozen and the slot is free or drained
   always_comb begin
      load   = !stall && (!ifid_valid || id_ready);
      rd_mis = redirect && (redirect_pc[1:0] != 2'b00);
   end

   // instruction memory is word indexed
   assign imem_addr = {2'b00, pc[31:2]};

   // pc, IF/ID register, misalign pulse and fetch counter
   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         ifid_valid  <= 1'b0;
         ifid_pc     <= 32'h0;
         ifid_instr  <= 32'h0;
         misalign    <= 1'b0;
         fetch_count <= 32'h0;
      end else begin
         misalign <= rd_mis;
         if (redirect) begin
            pc         <= {redirect_pc[31:2], 2'b00};
            ifid_valid <= 1'b0;
         end else if (load) begin
            ifid_instr  <= imem_rdata;
            ifid_pc     <= pc;
            ifid_valid  <= 1'b1;
            pc          <= pc + 32'd4;
            fetch_count <= fetch_count + 32'd1;
         end
      end
   end

endmodule
